// File: rtl/sm_ram_ctrl_pkg.sv
// Shared definitions for the per-node data-RAM responder: request codes
// seen on the core's AGU interface and the controller state encoding.
package sm_ram_ctrl_pkg;

    // Request codes driven by the core's address-generation unit
    localparam logic [2:0] AGU_IDLE  = 3'd0;
    localparam logic [2:0] AGU_LOAD  = 3'd1;
    localparam logic [2:0] AGU_STORE = 3'd2;

    // Latency counter width; covers the full 1..15 latency range
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        RAMC_IDLE = 2'd0,
        RAMC_WAIT = 2'd1,
        RAMC_ACK  = 2'd2
    } ramc_state_t;

    // Only LOAD and STORE start a transaction; any other code is idle
    function automatic logic is_request(input logic [2:0] code);
        return (code == AGU_LOAD) || (code == AGU_STORE);
    endfunction

endpackage

// File: rtl/sm_ram_array.sv
// Single-port synchronous word RAM with a registered, read-enabled output.
// The output register keeps its value between reads so the controller can
// present it as held load data.
module sm_ram_array #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Storage write port
    // NOTE: the array has no reset so it maps onto block RAM; contents survive rst_n.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Registered read port, updated only on an enabled read
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/sm_ram_ctrl.sv
// Responder for one core's data-memory requests. Captures a held LOAD or
// STORE, waits LATENCY cycles from the request, then issues exactly one
// acknowledge pulse (dataReceived or instrTaken) and returns to idle.
module sm_ram_ctrl
    import sm_ram_ctrl_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2,
    parameter int NODE_ID = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  aguInstruction,
    input  logic [31:0] ramAddress,
    input  logic [31:0] dataFromCpu,
    output logic [31:0] dataToCpu,
    output logic        dataReceived,
    output logic        instrTaken,
    output logic        busy,
    output logic        errFlag
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
    // Node index is kept for per-node init/debug hooks; no functional use
    localparam int unused_node_id = NODE_ID;

    ramc_state_t       state;
    logic [AW-1:0]     idx_q;
    logic              oob_q;
    logic              store_q;
    logic [31:0]       data_q;
    logic [CNT_W-1:0]  cnt;
    logic              load_zero;

    logic [29:0]       live_idx;
    logic              live_oob;
    logic [AW-1:0]     cur_idx;
    logic              cur_oob;
    logic              cur_store;
    logic              enter_ack;
    logic              ram_we;
    logic              ram_re;
    logic [31:0]       ram_rdata;
    logic              unused_addr_bits;

    assign live_idx         = ramAddress[31:2];
    assign live_oob         = live_idx >= 30'(DEPTH);
    assign unused_addr_bits = ^ramAddress[1:0];

    // Select live request fields in IDLE, captured fields otherwise, and
    // decide whether this edge moves the controller into ACK
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        cur_idx   = idx_q;
        cur_oob   = oob_q;
        cur_store = store_q;
        enter_ack = 1'b0;
        case (state)
            RAMC_IDLE: begin
                cur_idx   = live_idx[AW-1:0];
                cur_oob   = live_oob;
                cur_store = (aguInstruction == AGU_STORE);
                enter_ack = is_request(aguInstruction) && (LATENCY == 1);
            end
            RAMC_WAIT: enter_ack = (cnt == CNT_W'(1));
            default:   ;
        endcase
        // Read on the edge entering ACK so data is valid during the pulse;
        // write on the edge that ends ACK. Reset suppresses both.
        ram_re = rst_n && enter_ack && !cur_store && !cur_oob;
        ram_we = rst_n && (state == RAMC_ACK) && store_q && !oob_q;
    end

    sm_ram_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (cur_idx),
        .wdata (data_q),
        .rdata (ram_rdata)
    );

    // Out-of-range loads read as zero; otherwise present the held RAM output
    assign dataToCpu = load_zero ? '0 : ram_rdata;

    // Request sequencer with registered acknowledge, busy and error outputs
    // NOTE: state is assigned with <= only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= RAMC_IDLE;
            idx_q        <= '0;
            oob_q        <= 1'b0;
            store_q      <= 1'b0;
            data_q       <= '0;
            cnt          <= '0;
            load_zero    <= 1'b0;
            dataReceived <= 1'b0;
            instrTaken   <= 1'b0;
            busy         <= 1'b0;
            errFlag      <= 1'b0;
        end else begin
            dataReceived <= 1'b0;
            instrTaken   <= 1'b0;
            case (state)
                RAMC_IDLE: begin
                    if (is_request(aguInstruction)) begin
                        idx_q   <= live_idx[AW-1:0];
                        oob_q   <= live_oob;
                        store_q <= (aguInstruction == AGU_STORE);
                        data_q  <= dataFromCpu;
                        cnt     <= CNT_INIT;
                        busy    <= 1'b1;
                        errFlag <= errFlag | live_oob;
                        state   <= enter_ack ? RAMC_ACK : RAMC_WAIT;
                    end
                end
                RAMC_WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (enter_ack) begin
                        state <= RAMC_ACK;
                    end
                end
                RAMC_ACK: begin
                    busy  <= 1'b0;
                    state <= RAMC_IDLE;
                end
                default: state <= RAMC_IDLE;
            endcase
            if (enter_ack) begin
                if (cur_store) begin
                    instrTaken <= 1'b1;
                end else begin
                    dataReceived <= 1'b1;
                    load_zero    <= cur_oob;
                end
            end
        end
    end

endmodule

// File: tb/tb_sm_ram_ctrl.sv
// Directed bench for sm_ram_ctrl: one instance at LATENCY=2 (dut_a) and one
// at LATENCY=1 (dut_b), driven with the same request stream.
module tb_sm_ram_ctrl;
    import sm_ram_ctrl_pkg::*;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  agu_a, agu_b;
    logic [31:0] addr_a, addr_b, wd_a, wd_b;
    logic [31:0] rd_a, rd_b;
    logic        dr_a, dr_b, it_a, it_b, busy_a, busy_b, err_a, err_b;

    always #5 clk = ~clk;

    sm_ram_ctrl #(.DEPTH(DEPTH), .LATENCY(2), .NODE_ID(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .aguInstruction(agu_a), .ramAddress(addr_a),
        .dataFromCpu(wd_a), .dataToCpu(rd_a), .dataReceived(dr_a),
        .instrTaken(it_a), .busy(busy_a), .errFlag(err_a)
    );

    sm_ram_ctrl #(.DEPTH(DEPTH), .LATENCY(1), .NODE_ID(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .aguInstruction(agu_b), .ramAddress(addr_b),
        .dataFromCpu(wd_b), .dataToCpu(rd_b), .dataReceived(dr_b),
        .instrTaken(it_b), .busy(busy_b), .errFlag(err_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Per-transaction observations, index 0 = dut_a, 1 = dut_b
    int          p1[2], p2[2], npl[2], nld[2], nst[2], nbusy[2];
    logic [31:0] d1[2], d2[2];
    int          idle_pulses, idle_busy;
    int          viol = 0;
    logic        prev_a = 1'b0, prev_b = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Acknowledge protocol monitor: never both pulses, never two in a row
    always @(negedge clk) begin
        if (rst_n) begin
            if ((dr_a && it_a) || (dr_b && it_b)) viol++;
            if ((dr_a || it_a) && prev_a) viol++;
            if ((dr_b || it_b) && prev_b) viol++;
        end
        prev_a = dr_a || it_a;
        prev_b = dr_b || it_b;
    end

    task automatic sample(input int k);
        for (int d = 0; d < 2; d++) begin
            logic pd, pi, b;
            logic [31:0] dv;
            pd = (d == 0) ? dr_a   : dr_b;
            pi = (d == 0) ? it_a   : it_b;
            b  = (d == 0) ? busy_a : busy_b;
            dv = (d == 0) ? rd_a   : rd_b;
            if (pd || pi) begin
                npl[d]++;
                if (p1[d] < 0) p1[d] = k;
                else if (p2[d] < 0) p2[d] = k;
            end
            if (pd) begin
                nld[d]++;
                if (nld[d] == 1) d1[d] = dv;
                else d2[d] = dv;
            end
            if (pi) nst[d]++;
            if (b) nbusy[d]++;
        end
    endtask

    // Request held for cycles T..T+hold-1; afterwards the address and data
    // are scrambled so only captured values can produce correct results.
    // rst_at > 0 pulls rst_n low during cycle T+rst_at.
    task automatic txn(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                       input int hold, input bit en_b, input int rst_at);
        for (int d = 0; d < 2; d++) begin
            p1[d] = -1; p2[d] = -1; npl[d] = 0; nld[d] = 0; nst[d] = 0; nbusy[d] = 0;
            d1[d] = 32'hx; d2[d] = 32'hx;
        end
        @(posedge clk); #1;
        agu_a = op;  addr_a = addr; wd_a = data;
        agu_b = en_b ? op : AGU_IDLE; addr_b = addr; wd_b = data;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (k >= hold) begin
                agu_a = AGU_IDLE; addr_a = addr ^ 32'h40; wd_a = ~data;
                agu_b = AGU_IDLE; addr_b = addr ^ 32'h40; wd_b = ~data;
            end
            rst_n = (k == rst_at) ? 1'b0 : 1'b1;
            @(negedge clk);
            sample(k);
        end
    endtask

    task automatic idle_run(input int n);
        idle_pulses = 0;
        idle_busy   = 0;
        @(posedge clk); #1;
        agu_a = AGU_IDLE; agu_b = AGU_IDLE;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (dr_a || it_a || dr_b || it_b) idle_pulses++;
            if (busy_a || busy_b) idle_busy++;
            addr_a = 32'h10 + 32'(i * 4);
            addr_b = addr_a;
        end
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        agu_a = AGU_IDLE; addr_a = '0; wd_a = '0;
        agu_b = AGU_IDLE; addr_b = '0; wd_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_a_data", rd_a, 32'h0);
        check("rst_a_flags", {28'h0, dr_a, it_a, busy_a, err_a}, 32'h0);
        check("rst_b_data", rd_b, 32'h0);
        check("rst_b_flags", {28'h0, dr_b, it_b, busy_b, err_b}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        idle_run(20);
        check("idle_pulses", idle_pulses, 0);
        check("idle_busy", idle_busy, 0);

        txn(AGU_STORE, 32'h50, 32'h0BAD_F00D, 1, 1'b1, -1);
        check("st50_a_lat", p1[0], 2);
        check("st50_b_lat", p1[1], 1);

        txn(AGU_STORE, 32'h10, 32'hDEAD_BEEF, 1, 1'b1, -1);
        check("st10_a_lat", p1[0], 2);
        check("st10_a_nst", nst[0], 1);
        check("st10_a_npl", npl[0], 1);
        check("st10_a_busy", nbusy[0], 2);
        check("st10_b_lat", p1[1], 1);
        check("st10_b_nst", nst[1], 1);
        check("st10_b_busy", nbusy[1], 1);

        txn(AGU_LOAD, 32'h10, 32'h0, 1, 1'b1, -1);
        check("ld10_a_lat", p1[0], 2);
        check("ld10_a_nld", nld[0], 1);
        check("ld10_a_data", d1[0], 32'hDEAD_BEEF);
        check("ld10_a_busy", nbusy[0], 2);
        check("ld10_b_lat", p1[1], 1);
        check("ld10_b_data", d1[1], 32'hDEAD_BEEF);
        check("ld10_a_hold", rd_a, 32'hDEAD_BEEF);

        txn(AGU_LOAD, 32'h10, 32'h0, 4, 1'b1, -1);
        check("b2b_a_p1", p1[0], 2);
        check("b2b_a_p2", p2[0], 5);
        check("b2b_a_npl", npl[0], 2);
        check("b2b_a_d1", d1[0], 32'hDEAD_BEEF);
        check("b2b_a_d2", d2[0], 32'hDEAD_BEEF);
        check("b2b_b_p1", p1[1], 1);
        check("b2b_b_p2", p2[1], 3);
        check("b2b_b_d2", d2[1], 32'hDEAD_BEEF);

        txn(AGU_STORE, 32'h4, 32'd7, 1, 1'b1, -1);
        check("st4_b_lat", p1[1], 1);
        txn(AGU_LOAD, 32'h4, 32'h0, 1, 1'b1, -1);
        check("ld4_b_lat", p1[1], 1);
        check("ld4_b_data", d1[1], 32'd7);
        check("ld4_b_busy", nbusy[1], 1);
        check("ld4_a_data", d1[0], 32'd7);

        txn(AGU_STORE, 32'hFFC, 32'h1234_5678, 1, 1'b1, -1);
        txn(AGU_LOAD, 32'hFFC, 32'h0, 1, 1'b1, -1);
        check("top_a_data", d1[0], 32'h1234_5678);
        check("top_b_data", d1[1], 32'h1234_5678);

        txn(AGU_LOAD, 32'h0000_1000, 32'h0, 1, 1'b1, -1);
        check("oob_a_lat", p1[0], 2);
        check("oob_a_data", d1[0], 32'h0);
        check("oob_a_err", err_a, 1'b1);
        check("oob_b_lat", p1[1], 1);
        check("oob_b_data", d1[1], 32'h0);
        check("oob_b_err", err_b, 1'b1);
        idle_run(10);
        check("oob_idle_pulses", idle_pulses, 0);
        check("oob_a_sticky", err_a, 1'b1);
        check("oob_b_sticky", err_b, 1'b1);

        txn(AGU_STORE, 32'h0000_1010, 32'h99, 1, 1'b1, -1);
        check("oobst_a_lat", p1[0], 2);
        check("oobst_a_nst", nst[0], 1);
        txn(AGU_LOAD, 32'h4, 32'h0, 1, 1'b1, -1);
        check("oobst_a_nowrite", d1[0], 32'd7);
        check("oobst_b_nowrite", d1[1], 32'd7);

        txn(AGU_STORE, 32'h20, 32'h1111_1111, 1, 1'b1, -1);
        txn(AGU_STORE, 32'h20, 32'd5, 1, 1'b0, 1);
        check("rst_mid_a_npl", npl[0], 0);
        check("rst_mid_b_npl", npl[1], 0);
        check("rst_mid_a_busy", busy_a, 1'b0);
        check("rst_mid_a_err", err_a, 1'b0);
        check("rst_mid_b_err", err_b, 1'b0);
        check("rst_mid_a_data", rd_a, 32'h0);
        txn(AGU_LOAD, 32'h20, 32'h0, 1, 1'b1, -1);
        check("rst_mid_a_keep", d1[0], 32'h1111_1111);
        check("rst_mid_b_keep", d1[1], 32'h1111_1111);

        check("ack_protocol", viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
